// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the shared regfile write port with pending scoreboard
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int IW = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wb0_valid,
  input  logic [IW-1:0]          wb0_reg,
  input  logic signed [XLEN-1:0] wb0_data,
  output logic                   wb0_ready,
  input  logic                   wb1_valid,
  input  logic [IW-1:0]          wb1_reg,
  input  logic signed [XLEN-1:0] wb1_data,
  output logic                   wb1_ready,
  input  logic                   alloc_en,
  input  logic [IW-1:0]          alloc_reg,
  output logic                   alloc_conflict,
  output logic [NREG-1:0]        pending,
  output logic [IW-1:0]          write_reg,
  output logic signed [XLEN-1:0] write_data,
  output logic                   write_en
);

  // last_grant_q is the port granted most recently; reset to 1 so port 0 wins the first tie
  logic                   last_grant_q, last_grant_d;
  logic                   write_en_q, write_en_d;
  logic [IW-1:0]          write_reg_q, write_reg_d;
  logic signed [XLEN-1:0] write_data_q, write_data_d;
  logic [NREG-1:0]        pending_q, pending_d;
  logic                   gnt0, gnt1, set_ok;

  always_comb begin
    gnt0 = wb0_valid & (~wb1_valid | last_grant_q);
    gnt1 = wb1_valid & (~wb0_valid | ~last_grant_q);

    last_grant_d = last_grant_q;
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
      write_en_d   = (wb0_reg != '0);
      write_reg_d  = wb0_reg;
      write_data_d = wb0_data;
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      write_en_d   = (wb1_reg != '0);
      write_reg_d  = wb1_reg;
      write_data_d = wb1_data;
    end

    // A port-1 write retiring the same register being reallocated must not lose the new allocation
    set_ok = alloc_en && (alloc_reg != '0) &&
             (!pending_q[alloc_reg] || (gnt1 && (wb1_reg == alloc_reg)));

    pending_d = pending_q;
    if (gnt1) begin
      pending_d[wb1_reg] = 1'b0;
    end
    if (set_ok) begin
      pending_d[alloc_reg] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign wb0_ready      = gnt0;
  assign wb1_ready      = gnt1;
  assign alloc_conflict = alloc_en & pending_q[alloc_reg];
  assign pending        = pending_q;
  assign write_en       = write_en_q;
  assign write_reg      = write_reg_q;
  assign write_data     = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized check of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;

  logic               clk = 1'b0;
  logic               rstn;
  logic               wb0_valid, wb1_valid, alloc_en;
  logic [4:0]         wb0_reg, wb1_reg, alloc_reg;
  logic signed [31:0] wb0_data, wb1_data;
  logic               wb0_ready, wb1_ready, alloc_conflict, write_en;
  logic [31:0]        pending;
  logic [4:0]         write_reg;
  logic signed [31:0] write_data;

  int total = 0;
  int bad   = 0;

  // model state: who won last, what the output stage should hold, which registers are pending
  int          last_m;
  bit          we_m;
  int          wreg_m;
  logic [31:0] wdata_m;
  bit          pend_m [32];
  bit          acc0_m, acc1_m;
  logic [31:0] rf [32];

  regfile_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rstn(rstn),
    .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .alloc_en(alloc_en), .alloc_reg(alloc_reg), .alloc_conflict(alloc_conflict),
    .pending(pending), .write_reg(write_reg), .write_data(write_data), .write_en(write_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner(input bit v0, input bit v1);
    if (v0 && v1) return (last_m == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    last_m  = 1;
    we_m    = 0;
    wreg_m  = 0;
    wdata_m = '0;
    acc0_m  = 0;
    acc1_m  = 0;
    for (int i = 0; i < 32; i++) pend_m[i] = 0;
  endtask

  task automatic check();
    int          w;
    logic [31:0] pv;
    w = winner(wb0_valid, wb1_valid);
    for (int i = 0; i < 32; i++) pv[i] = pend_m[i];
    chk("wb0_ready", {63'd0, wb0_ready}, {63'd0, (w == 0)});
    chk("wb1_ready", {63'd0, wb1_ready}, {63'd0, (w == 1)});
    chk("alloc_conflict", {63'd0, alloc_conflict}, {63'd0, (alloc_en && pend_m[alloc_reg])});
    chk("pending", {32'd0, pending}, {32'd0, pv});
    chk("write_en", {63'd0, write_en}, {63'd0, we_m});
    chk("write_reg", {59'd0, write_reg}, 64'(wreg_m));
    chk("write_data", {32'd0, write_data}, {32'd0, wdata_m});
  endtask

  task automatic advance();
    int w;
    bit setok;
    if (!rstn) return;
    if (write_en && write_reg != 0) rf[write_reg] = write_data;
    w = winner(wb0_valid, wb1_valid);
    setok = alloc_en && alloc_reg != 0 &&
            (!pend_m[alloc_reg] || (w == 1 && wb1_reg == alloc_reg));
    if (w == 1) pend_m[wb1_reg] = 0;
    if (setok) pend_m[alloc_reg] = 1;
    acc0_m = (w == 0);
    acc1_m = (w == 1);
    if (w == 0) begin
      last_m = 0; we_m = (wb0_reg != 0); wreg_m = wb0_reg; wdata_m = wb0_data;
    end else if (w == 1) begin
      last_m = 1; we_m = (wb1_reg != 0); wreg_m = wb1_reg; wdata_m = wb1_data;
    end else begin
      we_m = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb0_valid = 0; wb1_valid = 0; alloc_en = 0;
  endtask

  initial begin
    rstn = 0;
    wb0_valid = 0; wb0_reg = 0; wb0_data = 0;
    wb1_valid = 0; wb1_reg = 0; wb1_data = 0;
    alloc_en = 0; alloc_reg = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    model_reset();
    #2;
    chk("rst_write_en", {63'd0, write_en}, 64'd0);
    chk("rst_pending", {32'd0, pending}, 64'd0);
    @(posedge clk); #1;
    rstn = 1;

    // single write, then asynchronous reset pulse mid-cycle
    wb0_valid = 1; wb0_reg = 10; wb0_data = 12983;
    #1 chk("w10_ready", {63'd0, wb0_ready}, 64'd1);
    step();
    idle_inputs();
    chk("w10_we", {63'd0, write_en}, 64'd1);
    chk("w10_reg", {59'd0, write_reg}, 64'd10);
    chk("w10_data", {32'd0, write_data}, 64'd12983);
    step();
    chk("rf10", {32'd0, rf[10]}, 64'd12983);
    #2 rstn = 0;
    #1;
    chk("pulse_we", {63'd0, write_en}, 64'd0);
    chk("pulse_reg", {59'd0, write_reg}, 64'd0);
    chk("pulse_data", {32'd0, write_data}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1;

    // contention: port 0 first, then port 1, then port 0 again
    wb0_valid = 1; wb0_reg = 5; wb0_data = 111;
    wb1_valid = 1; wb1_reg = 6; wb1_data = 222;
    #1 chk("rr1_ready0", {62'd0, wb1_ready, wb0_ready}, 64'd1);
    step();
    wb0_valid = 0;
    chk("rr_out1", {write_en, write_reg, write_data}, {1'b1, 5'd5, 32'd111});
    chk("rr2_ready1", {62'd0, wb1_ready, wb0_ready}, 64'd2);
    step();
    chk("rr_out2", {write_en, write_reg, write_data}, {1'b1, 5'd6, 32'd222});
    wb0_valid = 1; wb0_reg = 8; wb0_data = 333;
    wb1_valid = 1; wb1_reg = 9; wb1_data = 444;
    #1 chk("rr3_ready0", {62'd0, wb1_ready, wb0_ready}, 64'd1);
    step();
    wb0_valid = 0;
    step();
    idle_inputs();
    step();

    // scoreboard set, conflict, clear on port-1 completion
    alloc_en = 1; alloc_reg = 30;
    step();
    chk("pend30_set", {63'd0, pending[30]}, 64'd1);
    #1 chk("conflict30", {63'd0, alloc_conflict}, 64'd1);
    step();
    alloc_en = 0;
    chk("pend30_hold", {63'd0, pending[30]}, 64'd1);
    wb1_valid = 1; wb1_reg = 30; wb1_data = 324;
    step();
    wb1_valid = 0;
    chk("pend30_clr", {63'd0, pending[30]}, 64'd0);
    step();
    chk("rf30", {32'd0, rf[30]}, 64'd324);

    // clear and set of the same register at one edge: set wins
    alloc_en = 1; alloc_reg = 7;
    step();
    wb1_valid = 1; wb1_reg = 7; wb1_data = 77;
    step();
    idle_inputs();
    chk("pend7_setwins", {63'd0, pending[7]}, 64'd1);
    chk("w7_issued", {write_en, write_reg}, {1'b1, 5'd7});

    // x0 suppression
    wb0_valid = 1; wb0_reg = 0; wb0_data = 500;
    #1 chk("x0_ready", {63'd0, wb0_ready}, 64'd1);
    step();
    wb0_valid = 0;
    chk("x0_we", {63'd0, write_en}, 64'd0);
    alloc_en = 1; alloc_reg = 0;
    #1 chk("x0_conflict", {63'd0, alloc_conflict}, 64'd0);
    step();
    alloc_en = 0;
    chk("x0_pend", {63'd0, pending[0]}, 64'd0);
    chk("rf0", {32'd0, rf[0]}, 64'd0);

    // reset while a port-1 write sits in the output stage
    alloc_en = 1; alloc_reg = 12;
    step();
    alloc_en = 0;
    wb1_valid = 1; wb1_reg = 12; wb1_data = 99;
    step();
    wb1_valid = 0;
    #2 rstn = 0;
    #1;
    chk("midrst_we", {63'd0, write_en}, 64'd0);
    chk("midrst_pend", {32'd0, pending}, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    step();
    chk("midrst_after_we", {63'd0, write_en}, 64'd0);

    // randomized traffic; an unaccepted request is held stable until granted
    for (int n = 0; n < 1500; n++) begin
      if (!wb0_valid || acc0_m) begin
        wb0_valid = ($urandom_range(0, 9) < 6);
        wb0_reg   = 5'($urandom_range(0, 31));
        wb0_data  = $urandom;
      end
      if (!wb1_valid || acc1_m) begin
        wb1_valid = ($urandom_range(0, 9) < 5);
        wb1_reg   = 5'($urandom_range(0, 31));
        wb1_data  = $urandom;
      end
      alloc_en  = ($urandom_range(0, 3) == 0);
      alloc_reg = 5'($urandom_range(0, 31));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
